regfile_wb_arbiter: RTL and testbench

Write-port arbiter and load scoreboard for the 32×32 integer register file. It shares the register file's single write port between the execute-result path and the load-return path, and drives the registered write enable, address and data. It tracks registers with outstanding loads so the decode stage can stall on RAW/WAW hazards, and it provides bypass data for the write in flight.

---
 rtl/rv_pkg.sv | 17 +
 rtl/wb_scoreboard.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions used by the register-file write-back path.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    typedef enum logic {
        LD_PRIO = 1'b0,
        EX_PRIO = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set at load issue, cleared at load return.
module wb_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic                 clr,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    logic [NREG-1:0] sb;
    logic            set;

    assign issue_ready = !sb[issue_rd];
    assign set         = issue && issue_ready && (issue_rd != '0);
    assign rs1_busy    = sb[rs1] && (rs1 != '0);
    assign rs2_busy    = sb[rs2] && (rs2 != '0);

    // Clear has priority so a stray same-cycle issue cannot leave a bit stuck.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sb <= '0;
        end else begin
            sb[0] <= 1'b0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (clr && clr_rd == REG_IDX_W'(i)) begin
                    sb[i] <= 1'b0;
                end else if (set && issue_rd == REG_IDX_W'(i)) begin
                    sb[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between execute results and load returns,
// with a starvation limit for execute, a load scoreboard and write bypass.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = rv_pkg::XLEN,
    parameter int unsigned NREG     = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [XLEN-1:0]      ex_data,
    output logic                 ex_ready,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 ld_ready,
    input  logic                 ld_issue,
    input  logic [REG_IDX_W-1:0] ld_issue_rd,
    output logic                 ld_issue_ready,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 fwd1_en,
    output logic                 fwd2_en,
    output logic [XLEN-1:0]      fwd1_data,
    output logic [XLEN-1:0]      fwd2_data,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_reg,
    output logic [XLEN-1:0]      wr_data
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    wb_arb_state_e state;
    logic [3:0]    wait_cnt;
    wb_req_t       win;
    logic          accept;

    always_comb begin
        ex_ready = 1'b0;
        ld_ready = 1'b0;
        if (state == LD_PRIO) begin
            ld_ready = ld_valid;
            ex_ready = ex_valid && !ld_valid;
        end else begin
            ex_ready = ex_valid;
            ld_ready = ld_valid && !ex_valid;
        end
    end

    always_comb begin
        win.rd   = ld_rd;
        win.data = ld_data;
        if (ex_ready) begin
            win.rd   = ex_rd;
            win.data = ex_data;
        end
    end

    assign accept = ex_ready || ld_ready;

    // The limit is compared against the registered count, so priority flips one cycle after it is reached.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= LD_PRIO;
            wait_cnt <= '0;
            wr_en    <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
        end else begin
            if (!ex_valid || ex_ready) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            case (state)
                LD_PRIO: if (wait_cnt == WAIT_LIMIT && ex_valid && !ex_ready) state <= EX_PRIO;
                EX_PRIO: if (ex_ready || !ex_valid) state <= LD_PRIO;
                default: state <= LD_PRIO;
            endcase

            wr_en <= accept && (win.rd != '0);
            if (accept) begin
                wr_reg  <= win.rd;
                wr_data <= win.data;
            end
        end
    end

    wb_scoreboard #(
        .NREG(NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_       (rst_),
        .issue      (ld_issue),
        .issue_rd   (ld_issue_rd),
        .issue_ready(ld_issue_ready),
        .clr        (ld_valid && ld_ready),
        .clr_rd     (ld_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    assign fwd1_en   = wr_en && (wr_reg == rs1) && (rs1 != '0);
    assign fwd2_en   = wr_en && (wr_reg == rs2) && (rs2 != '0);
    assign fwd1_data = wr_data;
    assign fwd2_data = wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ex_valid, ld_valid, ld_issue;
    logic [4:0]  ex_rd, ld_rd, ld_issue_rd, rs1, rs2;
    logic [31:0] ex_data, ld_data;
    logic        ex_ready, ld_ready, ld_issue_ready;
    logic        rs1_busy, rs2_busy, fwd1_en, fwd2_en, wr_en;
    logic [31:0] fwd1_data, fwd2_data, wr_data;
    logic [4:0]  wr_reg;

    int unsigned tests_run = 0;
    int unsigned failed    = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN(32),
        .NREG(32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_(rst_),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ld_valid = 0; ld_issue = 0;
        ex_rd = 0; ld_rd = 0; ld_issue_rd = 0; rs1 = 0; rs2 = 0;
        ex_data = 0; ld_data = 0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        idle_inputs();
        #2;
        tests_run++;
        if ({wr_en, wr_reg, wr_data} !== 38'd0) begin
            failed++; $display("FAIL reset_wr: got en=%b reg=%0d data=%h want 0/0/0", wr_en, wr_reg, wr_data);
        end
        tests_run++;
        if ({rs1_busy, rs2_busy, ld_issue_ready, ex_ready, ld_ready} !== 5'b00100) begin
            failed++; $display("FAIL reset_comb: got %b want 00100", {rs1_busy, rs2_busy, ld_issue_ready, ex_ready, ld_ready});
        end
        #10 rst_ = 1'b1;
        tick();
    endtask

    task automatic test_solo_ex();
        ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if ({ex_ready, ld_ready} !== 2'b10) begin
            failed++; $display("FAIL solo_ex_ready: got %b want 10", {ex_ready, ld_ready});
        end
        tick();
        ex_valid = 0;
        tests_run++;
        if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failed++; $display("FAIL solo_ex_write: got en=%b reg=%0d data=%h want 1/5/deadbeef", wr_en, wr_reg, wr_data);
        end
        tick();
        tests_run++;
        if (wr_en !== 1'b0) begin
            failed++; $display("FAIL solo_ex_idle: got wr_en=%b want 0", wr_en);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exd, ldd;
        for (int c = 0; c < 10; c++) begin
            exd = $urandom; ldd = $urandom;
            ex_valid = 1; ex_rd = 9;  ex_data = exd;
            ld_valid = 1; ld_rd = 10; ld_data = ldd;
            #1;
            tests_run++;
            if ({ex_ready, ld_ready} !== ((c == 5) ? 2'b10 : 2'b01)) begin
                failed++; $display("FAIL contention_ready c=%0d: got %b want %b", c, {ex_ready, ld_ready}, (c == 5) ? 2'b10 : 2'b01);
            end
            tick();
            tests_run++;
            if ({wr_en, wr_reg, wr_data} !== ((c == 5) ? {1'b1, 5'd9, exd} : {1'b1, 5'd10, ldd})) begin
                failed++; $display("FAIL contention_write c=%0d: got reg=%0d data=%h", c, wr_reg, wr_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0_drop();
        ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
        #1;
        tests_run++;
        if ({ld_ready, ex_ready} !== 2'b10) begin
            failed++; $display("FAIL x0_ready: got %b want 10", {ld_ready, ex_ready});
        end
        tick();
        ld_valid = 0; rs1 = 7; rs2 = 10;
        #1;
        tests_run++;
        if ({wr_en, rs1_busy, rs2_busy, fwd1_en, fwd2_en} !== 5'b00000) begin
            failed++; $display("FAIL x0_nowrite: got %b want 00000", {wr_en, rs1_busy, rs2_busy, fwd1_en, fwd2_en});
        end
        tick();
    endtask

    task automatic test_scoreboard();
        logic [31:0] d;
        d = $urandom;
        ld_issue = 1; ld_issue_rd = 7; rs1 = 7; rs2 = 0;
        #1;
        tests_run++;
        if ({ld_issue_ready, rs1_busy} !== 2'b10) begin
            failed++; $display("FAIL sb_first_issue: got %b want 10", {ld_issue_ready, rs1_busy});
        end
        tick();
        rs2 = 7;
        #1;
        tests_run++;
        if ({ld_issue_ready, rs1_busy, rs2_busy} !== 3'b011) begin
            failed++; $display("FAIL sb_waw_stall: got %b want 011", {ld_issue_ready, rs1_busy, rs2_busy});
        end
        tick();
        ld_issue = 0; ld_valid = 1; ld_rd = 7; ld_data = d;
        #1;
        tests_run++;
        if ({ld_ready, rs1_busy} !== 2'b11) begin
            failed++; $display("FAIL sb_return: got %b want 11", {ld_ready, rs1_busy});
        end
        tick();
        ld_valid = 0;
        #1;
        tests_run++;
        if ({rs1_busy, fwd1_en, fwd1_data, ld_issue_ready} !== {1'b0, 1'b1, d, 1'b1}) begin
            failed++; $display("FAIL sb_clear_fwd: got busy=%b fwd=%b data=%h want 0/1/%h", rs1_busy, fwd1_en, fwd1_data, d);
        end
        // Same-index issue and return in one cycle: the return's clear must win.
        ld_issue = 1; ld_issue_rd = 8; ld_valid = 1; ld_rd = 8; rs1 = 8;
        tick();
        idle_inputs(); rs1 = 8;
        #1;
        tests_run++;
        if ({rs1_busy, ld_issue_ready} !== 2'b01) begin
            failed++; $display("FAIL sb_clear_wins: got %b want 01", {rs1_busy, ld_issue_ready});
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [31:0] d;
        d = $urandom;
        ex_valid = 1; ex_rd = 3; ex_data = d;
        tick();
        ex_valid = 0; rs1 = 4; rs2 = 3;
        #1;
        tests_run++;
        if ({fwd2_en, fwd2_data, fwd1_en} !== {1'b1, d, 1'b0}) begin
            failed++; $display("FAIL fwd_hit: got en2=%b data2=%h en1=%b want 1/%h/0", fwd2_en, fwd2_data, fwd1_en, d);
        end
        tick();
        ex_valid = 1; ex_rd = 0; ex_data = $urandom;
        tick();
        ex_valid = 0; rs2 = 0;
        #1;
        tests_run++;
        if ({wr_en, wr_reg, fwd2_en} !== {1'b0, 5'd0, 1'b0}) begin
            failed++; $display("FAIL fwd_x0: got en=%b reg=%0d fwd2=%b want 0/0/0", wr_en, wr_reg, fwd2_en);
        end
        tick();
    endtask

    task automatic test_async_reset();
        ld_issue = 1; ld_issue_rd = 12;
        tick();
        ld_issue = 0;
        for (int c = 0; c < 3; c++) begin
            ex_valid = 1; ex_rd = 13; ex_data = $urandom;
            ld_valid = 1; ld_rd = 20; ld_data = $urandom;
            tick();
        end
        rs1 = 12; ld_issue_rd = 12;
        #1;
        tests_run++;
        if ({rs1_busy, wr_en, ex_ready} !== 3'b110) begin
            failed++; $display("FAIL rst_pre: got %b want 110", {rs1_busy, wr_en, ex_ready});
        end
        rst_ = 1'b0;
        #1;
        tests_run++;
        if ({wr_en, wr_reg, wr_data, rs1_busy, ld_issue_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            failed++; $display("FAIL rst_immediate: got en=%b reg=%0d data=%h busy=%b iss=%b", wr_en, wr_reg, wr_data, rs1_busy, ld_issue_ready);
        end
        idle_inputs();
        #1 rst_ = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            ex_valid = 1; ex_rd = 13; ex_data = 32'hE0 + c;
            ld_valid = 1; ld_rd = 12; ld_data = 32'hA0 + c;
            rs1 = 12; rs2 = 13;
            #1;
            tests_run++;
            if ({ex_ready, ld_ready, rs1_busy, rs2_busy} !== ((c == 5) ? 4'b1000 : 4'b0100)) begin
                failed++; $display("FAIL rst_post_arb c=%0d: got %b", c, {ex_ready, ld_ready, rs1_busy, rs2_busy});
            end
            tick();
            tests_run++;
            if ({wr_en, wr_reg, wr_data} !== ((c == 5) ? {1'b1, 5'd13, 32'hE0 + c} : {1'b1, 5'd12, 32'hA0 + c})) begin
                failed++; $display("FAIL rst_post_write c=%0d: got reg=%0d data=%h", c, wr_reg, wr_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit          m_sb [32];
        bit          m_exprio, e_ex, e_ld, e_iss, acc;
        int unsigned m_wait;
        bit          m_wr_en;
        logic [4:0]  m_wr_reg, w_rd;
        logic [31:0] m_wr_data, w_data;
        logic [6:0]  exp_c, got_c;

        idle_inputs();
        rst_ = 1'b0;
        #2 rst_ = 1'b1;
        foreach (m_sb[i]) m_sb[i] = 0;
        m_exprio = 0; m_wait = 0; m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0;
        tick();

        for (int n = 0; n < 400; n++) begin
            ex_valid = ($urandom_range(0, 3) != 0);
            ld_valid = ($urandom_range(0, 3) != 0);
            ex_rd = 5'($urandom_range(0, 7)); ex_data = $urandom;
            ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            ld_issue = ($urandom_range(0, 1) != 0);
            ld_issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            #1;
            // Whoever holds priority wins; the other side only gets the port when the favoured side is idle.
            e_ex  = m_exprio ? ex_valid : (ex_valid && !ld_valid);
            e_ld  = m_exprio ? (ld_valid && !ex_valid) : ld_valid;
            e_iss = !m_sb[ld_issue_rd];
            exp_c = {e_ex, e_ld, e_iss,
                     m_sb[rs1] && rs1 != 0, m_sb[rs2] && rs2 != 0,
                     m_wr_en && m_wr_reg == rs1 && rs1 != 0, m_wr_en && m_wr_reg == rs2 && rs2 != 0};
            got_c = {ex_ready, ld_ready, ld_issue_ready, rs1_busy, rs2_busy, fwd1_en, fwd2_en};
            tests_run++;
            if (got_c !== exp_c) begin
                failed++; $display("FAIL rand_comb n=%0d: got %b want %b", n, got_c, exp_c);
            end
            tests_run++;
            if ({fwd1_data, fwd2_data} !== {m_wr_data, m_wr_data}) begin
                failed++; $display("FAIL rand_fwd_data n=%0d: got %h/%h want %h", n, fwd1_data, fwd2_data, m_wr_data);
            end

            if (m_exprio) begin
                if (e_ex || !ex_valid) m_exprio = 0;
            end else if (m_wait == MAX_WAIT && ex_valid && !e_ex) begin
                m_exprio = 1;
            end
            m_wait = (ex_valid && !e_ex) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
            if (ld_issue && e_iss && ld_issue_rd != 0) m_sb[ld_issue_rd] = 1;
            if (e_ld) m_sb[ld_rd] = 0;
            acc    = e_ex || e_ld;
            w_rd   = e_ex ? ex_rd : ld_rd;
            w_data = e_ex ? ex_data : ld_data;
            m_wr_en = acc && w_rd != 0;
            if (acc) begin
                m_wr_reg = w_rd; m_wr_data = w_data;
            end

            tick();
            tests_run++;
            if ({wr_en, wr_reg, wr_data} !== {m_wr_en, m_wr_reg, m_wr_data}) begin
                failed++; $display("FAIL rand_write n=%0d: got %b/%0d/%h want %b/%0d/%h", n, wr_en, wr_reg, wr_data, m_wr_en, m_wr_reg, m_wr_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_solo_ex();
        test_contention();
        test_x0_drop();
        test_scoreboard();
        test_forwarding();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
